// File: rtl/ifu_pkg.sv
// Shared types and widths for the instruction fetch unit.
// Fetch entries pair a PC with the instruction word fetched from it.
package ifu_pkg;

  localparam int ADDR_W     = 17;
  localparam int INST_W     = 32;
  localparam int INST_BYTES = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Fetch buffer: circular FIFO of fetch entries with flush.
// Flush beats push and pop; head reads as zero when empty.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC register, fetch buffer, decode handshake.
// Define IFU_PERF_EN to add fetch and stall performance counters.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = 17'h00000,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        fetch_en,
  input  logic                        redirect_valid,
  input  logic [ADDR_W-1:0]           redirect_pc,
  output logic [ADDR_W-1:0]           imem_addr,
  input  logic [INST_W-1:0]           imem_inst,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [INST_W-1:0]           out_inst,
  output logic [ADDR_W-1:0]           out_pc,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
`ifdef IFU_PERF_EN
  ,
  output logic [31:0]                 perf_fetch_cnt,
  output logic [31:0]                 perf_stall_cnt
`endif
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] target;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  fetch_entry_t      wr_entry;
  fetch_entry_t      head;

  assign target    = redirect_pc & ~ADDR_W'(3);
  assign push      = fetch_en & ~full & ~redirect_valid;
  assign pop       = out_valid & out_ready & ~redirect_valid;
  assign imem_addr = pc;
  assign wr_entry  = '{pc: pc, inst: imem_inst};
  assign out_valid = ~empty;
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;

  // PC: redirect wins, otherwise advance one word per push.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= target;
    end else if (push) begin
      pc <= pc + ADDR_W'(INST_BYTES);
    end
  end

  ifu_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (redirect_valid),
    .push    (push),
    .pop     (pop),
    .din     (wr_entry),
    .dout    (head),
    .count   (fifo_count),
    .full    (full),
    .empty   (empty)
  );

`ifdef IFU_PERF_EN
  // Free-running wrap-around counters for pushes and full stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (push) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (fetch_en && full && !redirect_valid)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
